// File: rtl/note_player_pkg.sv
// Shared types and constants for the note player: FSM encoding, field widths
// and the latched note command payload.
package note_player_pkg;

   localparam int unsigned NOTE_W     = 6;
   localparam int unsigned DUR_W      = 6;
   localparam int unsigned STEP_W_DEF = 20;

   localparam logic [NOTE_W-1:0] REST_NOTE = '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PLAY = 2'd2,
      ST_WAIT = 2'd3
   } state_t;

   typedef struct packed {
      logic [NOTE_W-1:0] note;
      logic [DUR_W-1:0]  duration;
   } note_cmd_t;

endpackage

// File: rtl/note_player_if.sv
// Song-reader <-> note-player link: note stream and timing in, step/handshake out.
interface note_player_if
   import note_player_pkg::*;
#(
   parameter int unsigned STEP_W = STEP_W_DEF
);

   logic              play;
   logic [NOTE_W-1:0] note;
   logic [DUR_W-1:0]  duration;
   logic              new_note;
   logic              beat;
   logic [STEP_W-1:0] step_size;
   logic              note_done;
   logic              busy;

   modport master (
      output play, note, duration, new_note, beat,
      input  step_size, note_done, busy
   );

   modport slave (
      input  play, note, duration, new_note, beat,
      output step_size, note_done, busy
   );

endinterface

// File: rtl/note_player_frequency_rom.sv
// Note index -> phase step lookup, equal temperament with A4 (note 49) = 9200.
// Notes are A-based octaves: note 1 = A0; higher octaves are exact doublings.
module note_player_frequency_rom
   import note_player_pkg::*;
#(
   parameter int unsigned STEP_W = STEP_W_DEF
) (
   input  logic [NOTE_W-1:0] note,
   output logic [STEP_W-1:0] step
);

   // Octave-5 steps (A5..G#5); lower octaves are right shifts of these.
   function automatic logic [15:0] top_octave(input logic [3:0] semi);
      logic [15:0] val;
      case (semi)
         4'd0:    val = 16'd18400;
         4'd1:    val = 16'd19494;
         4'd2:    val = 16'd20653;
         4'd3:    val = 16'd21881;
         4'd4:    val = 16'd23183;
         4'd5:    val = 16'd24561;
         4'd6:    val = 16'd26022;
         4'd7:    val = 16'd27569;
         4'd8:    val = 16'd29208;
         4'd9:    val = 16'd30945;
         4'd10:   val = 16'd32785;
         4'd11:   val = 16'd34735;
         default: val = 16'd0;
      endcase
      return val;
   endfunction

   logic [NOTE_W-1:0] idx;
   logic [3:0]        semi;
   logic [2:0]        oct;

   always_comb begin
      idx  = note - NOTE_W'(1);
      semi = 4'(idx);
      oct  = 3'd0;
      for (int o = 1; o < 6; o++) begin
         if (idx >= NOTE_W'(12 * o)) begin
            semi = 4'(idx - NOTE_W'(12 * o));
            oct  = 3'(o);
         end
      end
      step = (note == REST_NOTE) ? '0 : STEP_W'(top_octave(semi) >> (3'd5 - oct));
   end

endmodule

// File: rtl/note_player.sv
// Holds each note from the song reader for its duration in beats, driving the
// phase step while sounding and pulsing note_done when the duration expires.
module note_player
   import note_player_pkg::*;
#(
   parameter int unsigned LOAD_DELAY = 2,
   parameter int unsigned STEP_W     = STEP_W_DEF
) (
   input  logic          clk,
   input  logic          reset,
   note_player_if.slave  bus
);

   localparam int unsigned      LCNT_W    = (LOAD_DELAY > 1) ? $clog2(LOAD_DELAY) : 1;
   localparam logic [LCNT_W-1:0] LOAD_LAST = LCNT_W'(LOAD_DELAY - 1);

   state_t            state_q, state_d;
   logic [LCNT_W-1:0] lcnt_q, lcnt_d;
   logic [DUR_W-1:0]  bcnt_q, bcnt_d;
   note_cmd_t         cmd_q, cmd_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic [STEP_W-1:0] rom_step;

   logic load_last;
   logic play_end;

   note_player_frequency_rom #(.STEP_W(STEP_W)) u_rom (
      .note (cmd_q.note),
      .step (rom_step)
   );

   assign load_last = (lcnt_q == LOAD_LAST);
   // Zero-length notes end immediately; otherwise end on the final counted beat.
   assign play_end  = (cmd_q.duration == '0) ||
                      (bus.play && bus.beat && ((bcnt_q + DUR_W'(1)) == cmd_q.duration));

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.play) state_d = ST_LOAD;
         ST_LOAD: if (!bus.new_note && load_last) state_d = ST_PLAY;
         ST_PLAY: begin
            if (bus.new_note)  state_d = ST_LOAD;
            else if (play_end) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.new_note)  state_d = ST_LOAD;
            else if (!bus.play) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath and output next values; new_note aborts any load or note in flight
   always_comb begin
      lcnt_d = '0;
      bcnt_d = bcnt_q;
      cmd_d  = cmd_q;
      step_d = '0;
      done_d = 1'b0;
      busy_d = (state_d == ST_LOAD) || (state_d == ST_PLAY);

      if (state_q == ST_LOAD && !bus.new_note) begin
         lcnt_d = lcnt_q + LCNT_W'(1);
         if (load_last) begin
            lcnt_d         = '0;
            cmd_d.note     = bus.note;
            cmd_d.duration = bus.duration;
            bcnt_d         = '0;
         end
      end

      if (state_q == ST_PLAY && !bus.new_note) begin
         if (bus.play && bus.beat) bcnt_d = bcnt_q + DUR_W'(1);
         done_d = play_end;
      end

      if (state_q == ST_PLAY && bus.play) step_d = rom_step;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lcnt_q <= '0;
         bcnt_q <= '0;
         cmd_q  <= '0;
         step_q <= '0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         lcnt_q <= lcnt_d;
         bcnt_q <= bcnt_d;
         cmd_q  <= cmd_d;
         step_q <= step_d;
         done_q <= done_d;
         busy_q <= busy_d;
      end
   end

   assign bus.step_size = step_q;
   assign bus.note_done = done_q;
   assign bus.busy      = busy_q;

endmodule
